// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit path: frame width, receiver
// synchroniser limit and the transmit FSM state encoding.
package spi_pkg;

  localparam int SPI_DATA_W   = 16;
  localparam int SPI_SYNC_MIN = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_tx_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Request handshake plus the three-wire SPI link of the transmit master.
interface spi_master_tx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) ();

  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_si;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, tx_done, spi_cs, spi_sck, spi_si
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, tx_done, spi_cs, spi_sck, spi_si
  );

endinterface

// File: rtl/spi_sck_div.sv
// Half-period divider for sck: strobes rise_tick/fall_tick every CLK_DIV
// cycles, alternating, starting from the low phase whenever en goes high.
module spi_sck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             high_q, high_d;
  logic             last;

  always_comb begin
    last      = (cnt_q == CNT_W'(CLK_DIV - 1));
    rise_tick = en && last && !high_q;
    fall_tick = en && last && high_q;
    cnt_d     = (!en || last) ? '0 : cnt_q + 1'b1;
    high_d    = !en ? 1'b0 : (last ? ~high_q : high_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// Transmit-only SPI master, mode 0, MSB first. spi_si is the MSB of the shift
// register, so zeros shifted in leave the line low once the frame ends.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 4
) (
  input logic            clk,
  input logic            rst_n,
  spi_master_tx_if.slave bus
);

  localparam int PHASE_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
  localparam int PHASE_W   = $clog2(PHASE_MAX);

  if (DATA_W != SPI_DATA_W) begin : g_bad_width
    $error("spi_master_tx: DATA_W must equal SPI_DATA_W");
  end
  if (CLK_DIV < SPI_SYNC_MIN) begin : g_bad_div
    $error("spi_master_tx: CLK_DIV below receiver synchroniser minimum");
  end
  if (CS_SETUP < CLK_DIV) begin : g_bad_setup
    $error("spi_master_tx: CS_SETUP must be at least CLK_DIV");
  end
  if (CS_HOLD < 1) begin : g_bad_hold
    $error("spi_master_tx: CS_HOLD must be at least 1");
  end
  if (CS_GAP < SPI_SYNC_MIN) begin : g_bad_gap
    $error("spi_master_tx: CS_GAP below receiver synchroniser minimum");
  end

  spi_tx_state_t      state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic rise_tick, fall_tick;
  logic setup_end, hold_end, gap_end, last_bit;

  spi_sck_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == SHIFT),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign setup_end = (phase_q == PHASE_W'(CS_SETUP - 1));
  assign hold_end  = (phase_q == PHASE_W'(CS_HOLD - 1));
  assign gap_end   = (phase_q == PHASE_W'(CS_GAP - 1));
  assign last_bit  = (bit_cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.tx_start)           state_d = SETUP;
      SETUP:   if (setup_end)              state_d = SHIFT;
      SHIFT:   if (fall_tick && last_bit)  state_d = HOLD;
      HOLD:    if (hold_end)               state_d = GAP;
      GAP:     if (gap_end)                state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Phase counter only runs in the timed chip-select states.
    if (state_d != state_q || state_q == IDLE || state_q == SHIFT) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          shreg_d = bus.tx_data;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (setup_end) bit_cnt_d = 4'(DATA_W - 1);
      end
      SHIFT: begin
        if (rise_tick) sck_d = 1'b1;
        if (fall_tick) begin
          sck_d   = 1'b0;
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (!last_bit) bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (hold_end) cs_d = 1'b1;
      end
      GAP: begin
        if (gap_end) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign bus.spi_cs  = cs_q;
  assign bus.spi_sck = sck_q;
  assign bus.spi_si  = shreg_q[DATA_W-1];

endmodule
